// File: rtl/sha256_pkg.sv
// SHA-256 / SHA-224 constants and round helper functions.
// Shared by the multi-block hashing core.
package sha256_pkg;

  localparam int BLOCK_SIZE = 256;

  localparam logic [255:0] IV256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [255:0] IV224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(
    input logic [31:0] x,
    input int unsigned n
  );
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_multiblock_core.sv
// Multi-block SHA-256/SHA-224 core, chained hash across blocks,
// ROUNDS_PER_CYCLE unrolled compression rounds per clock.
module sha256_multiblock_core
  import sha256_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    blk_valid_i,
  output logic                    blk_ready_o,
  input  logic [2*BLOCK_SIZE-1:0] blk_i,
  input  logic                    blk_first_i,
  input  logic                    blk_last_i,
  input  logic                    mode_i,
  output logic                    md_valid_o,
  input  logic                    md_ready_i,
  output logic [BLOCK_SIZE-1:0]   md_o,
  output logic                    busy_o,
  output logic [15:0]             blk_cnt_o
);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
        ROUNDS_PER_CYCLE == 4 || ROUNDS_PER_CYCLE == 8 ||
        ROUNDS_PER_CYCLE == 16)) begin : g_bad_rpc
    $fatal(1, "ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  localparam logic [5:0] RSTEP = 6'(ROUNDS_PER_CYCLE);
  localparam logic [5:0] RLAST = 6'(64 - ROUNDS_PER_CYCLE);

  typedef enum logic [2:0] {
    S_IDLE, S_ROUND, S_UPDATE, S_WAIT, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [31:0]  h_q  [8];
  logic [31:0]  wv_q [8];
  logic [31:0]  w_q  [16];
  logic [5:0]   rnd_q;
  logic         last_q;
  logic         mode_q;
  logic [15:0]  cnt_q;
  logic [255:0] md_q;

  logic [31:0]  st   [8];
  logic [31:0]  win  [16];
  logic [31:0]  hsum [8];
  logic [255:0] hcat;
  logic [255:0] base;
  logic [31:0]  t1, t2, nw;
  logic         accept, fresh, mode_sel;

  assign blk_ready_o = rstn_i &
    (state_q == S_IDLE || state_q == S_WAIT);
  assign accept     = blk_valid_i & blk_ready_o;
  assign md_valid_o = (state_q == S_DONE);
  assign busy_o     = (state_q != S_IDLE);
  assign md_o       = md_q;
  assign blk_cnt_o  = cnt_q;

  // A first block, or any block from IDLE, starts from the IV.
  assign fresh    = (state_q == S_IDLE) | blk_first_i;
  assign mode_sel = fresh ? mode_i : mode_q;

  always_comb begin
    base = '0;
    for (int i = 0; i < 8; i++) begin
      base[255-32*i -: 32] = fresh ?
        (mode_sel ? IV224[255-32*i -: 32] : IV256[255-32*i -: 32]) :
        h_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_ROUND;
      S_ROUND:  if (rnd_q == RLAST) state_d = S_UPDATE;
      S_UPDATE: state_d = last_q ? S_DONE : S_WAIT;
      S_WAIT:   if (accept) state_d = S_ROUND;
      S_DONE:   if (md_ready_i) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 8; i++) st[i] = wv_q[i];
    for (int i = 0; i < 16; i++) win[i] = w_q[i];
    t1 = '0;
    t2 = '0;
    nw = '0;
    for (int r = 0; r < ROUNDS_PER_CYCLE; r++) begin
      t1 = st[7] + bsig1(st[4]) +
           ((st[4] & st[5]) ^ (~st[4] & st[6])) +
           K[rnd_q + 6'(r)] + win[0];
      t2 = bsig0(st[0]) +
           ((st[0] & st[1]) ^ (st[0] & st[2]) ^ (st[1] & st[2]));
      nw = ssig1(win[14]) + win[9] + ssig0(win[1]) + win[0];
      for (int i = 7; i > 0; i--) st[i] = st[i-1];
      st[4] = st[4] + t1;
      st[0] = t1 + t2;
      for (int i = 0; i < 15; i++) win[i] = win[i+1];
      win[15] = nw;
    end
  end

  always_comb begin
    hcat = '0;
    for (int i = 0; i < 8; i++) begin
      hsum[i] = h_q[i] + wv_q[i];
      hcat[255-32*i -: 32] = hsum[i];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < 8; i++) begin
        h_q[i]  <= '0;
        wv_q[i] <= '0;
      end
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
      rnd_q  <= '0;
      last_q <= 1'b0;
      mode_q <= 1'b0;
      cnt_q  <= '0;
      md_q   <= '0;
    end else begin
      if (accept) begin
        for (int i = 0; i < 8; i++) begin
          h_q[i]  <= base[255-32*i -: 32];
          wv_q[i] <= base[255-32*i -: 32];
        end
        for (int i = 0; i < 16; i++) w_q[i] <= blk_i[511-32*i -: 32];
        rnd_q  <= '0;
        last_q <= blk_last_i;
        mode_q <= mode_sel;
        if (fresh) cnt_q <= '0;
      end else if (state_q == S_ROUND) begin
        for (int i = 0; i < 8; i++) wv_q[i] <= st[i];
        for (int i = 0; i < 16; i++) w_q[i] <= win[i];
        rnd_q <= rnd_q + RSTEP;
      end else if (state_q == S_UPDATE) begin
        for (int i = 0; i < 8; i++) h_q[i] <= hsum[i];
        if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
        if (last_q) md_q <= mode_q ? {hcat[255:32], 32'h0} : hcat;
      end
    end
  end

endmodule

// File: tb/tb_sha256_multiblock_core.sv
// Directed-vector bench for sha256_multiblock_core: one R=1 and
// one R=4 instance, known digests and cycle-exact latencies.
module tb_sha256_multiblock_core;

  logic         clk = 0;
  logic         rst_n = 0;
  logic         blk_valid [2];
  logic         blk_ready [2];
  logic [511:0] blk       [2];
  logic         blk_first [2];
  logic         blk_last  [2];
  logic         mode      [2];
  logic         md_valid  [2];
  logic         md_ready  [2];
  logic [255:0] md        [2];
  logic         busy      [2];
  logic [15:0]  cnt       [2];

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [511:0] B_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] B_ABC = {32'h61626380, 448'h0, 32'h18};
  localparam logic [511:0] B_M1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] B_M2 = {480'h0, 32'h1c0};

  localparam logic [255:0] D_EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_ABC224 = {
    224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0};
  localparam logic [255:0] D_M =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  sha256_multiblock_core #(.ROUNDS_PER_CYCLE(1)) u_r1 (
    .clk_i(clk), .rstn_i(rst_n),
    .blk_valid_i(blk_valid[0]), .blk_ready_o(blk_ready[0]),
    .blk_i(blk[0]), .blk_first_i(blk_first[0]),
    .blk_last_i(blk_last[0]), .mode_i(mode[0]),
    .md_valid_o(md_valid[0]), .md_ready_i(md_ready[0]),
    .md_o(md[0]), .busy_o(busy[0]), .blk_cnt_o(cnt[0])
  );

  sha256_multiblock_core #(.ROUNDS_PER_CYCLE(4)) u_r4 (
    .clk_i(clk), .rstn_i(rst_n),
    .blk_valid_i(blk_valid[1]), .blk_ready_o(blk_ready[1]),
    .blk_i(blk[1]), .blk_first_i(blk_first[1]),
    .blk_last_i(blk_last[1]), .mode_i(mode[1]),
    .md_valid_o(md_valid[1]), .md_ready_i(md_ready[1]),
    .md_o(md[1]), .busy_o(busy[1]), .blk_cnt_o(cnt[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Called #1 after a posedge; returns #1 after the accept edge.
  task automatic send(input int d, input logic [511:0] b,
                      input logic f, input logic l, input logic m);
    int n = 0;
    blk[d] = b;
    blk_first[d] = f;
    blk_last[d] = l;
    mode[d] = m;
    blk_valid[d] = 1;
    while (!blk_ready[d] && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!blk_ready[d]) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    blk_valid[d] = 0;
    blk[d] = ~b;
    blk_first[d] = ~f;
    blk_last[d] = ~l;
  endtask

  task automatic get_md(input int d, input int lat,
                        input logic [255:0] exp, input string tag);
    int n = 0;
    while (!md_valid[d] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, 256'(n), 256'(lat));
    chk(tag, md[d], exp);
  endtask

  task automatic pop(input int d, input string tag);
    md_ready[d] = 1;
    @(posedge clk); #1;
    md_ready[d] = 0;
    chk({tag, "_pop"}, {md_valid[d], busy[d], blk_ready[d]}, 3'b001);
  endtask

  task automatic to_wait(input int d);
    int n = 0;
    while (!blk_ready[d] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!blk_ready[d]) chk("wait_timeout", 0, 1);
  endtask

  initial begin
    logic [255:0] held;
    logic ok;
    for (int d = 0; d < 2; d++) begin
      blk_valid[d] = 0;
      blk[d] = '0;
      blk_first[d] = 0;
      blk_last[d] = 0;
      mode[d] = 0;
      md_ready[d] = 0;
    end

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {blk_ready[0], blk_ready[1]}, 0);
    chk("rst_outs", {md_valid[0], busy[0], cnt[0], md[0]}, 0);
    chk("rst_outs4", {md_valid[1], busy[1], cnt[1], md[1]}, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    chk("idle_ready", {blk_ready[0], blk_ready[1]}, 2'b11);

    // empty string, R=1
    send(0, B_EMPTY, 1, 1, 0);
    get_md(0, 65, D_EMPTY, "empty");
    chk("empty_cnt", cnt[0], 1);
    pop(0, "empty");

    // "abc", R=4, SHA-256 then SHA-224
    send(1, B_ABC, 1, 1, 0);
    get_md(1, 17, D_ABC, "abc");
    chk("abc_cnt", cnt[1], 1);

    // backpressure on the digest port
    held = md[1];
    ok = 1;
    repeat (10) begin
      @(posedge clk); #1;
      ok &= md_valid[1] & busy[1] & ~blk_ready[1] & (md[1] == held);
    end
    chk("bp_hold", ok, 1);
    pop(1, "bp");

    send(1, B_ABC, 1, 1, 1);
    get_md(1, 17, D_ABC224, "abc224");
    pop(1, "abc224");

    // two-block message with a 7-cycle gap in WAIT
    send(1, B_M1, 1, 0, 0);
    to_wait(1);
    chk("m_cnt1", cnt[1], 1);
    ok = 1;
    repeat (7) begin
      @(posedge clk); #1;
      ok &= blk_ready[1] & ~md_valid[1];
    end
    chk("m_gap_ready", ok, 1);
    send(1, B_M2, 0, 1, 1);
    get_md(1, 17, D_M, "two_blk");
    chk("m_cnt2", cnt[1], 2);
    pop(1, "two_blk");

    // restart in WAIT with a fresh single-block message
    send(1, B_M1, 1, 0, 1);
    to_wait(1);
    send(1, B_ABC, 1, 1, 0);
    get_md(1, 17, D_ABC, "restart");
    chk("restart_cnt", cnt[1], 1);
    pop(1, "restart");

    // reset mid-ROUND on the R=1 core
    send(0, B_ABC, 1, 1, 0);
    repeat (30) @(posedge clk);
    #1;
    chk("mid_busy", busy[0], 1);
    rst_n = 0;
    #1;
    chk("mid_rst", {md_valid[0], busy[0], blk_ready[0], cnt[0], md[0]}, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    send(0, B_ABC, 1, 1, 0);
    get_md(0, 65, D_ABC, "post_rst");
    chk("post_rst_cnt", cnt[0], 1);
    pop(0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sha256_multiblock_core.md
# sha256_multiblock_core

Parametrised successor to `sha256_core`. It hashes messages of any number of pre-padded 512-bit blocks by chaining the intermediate hash across blocks. It supports SHA-256 and SHA-224 and a configurable number of compression rounds per clock. It sits between a padding/DMA front end, which uses a valid/ready block stream, and a result consumer, which uses a valid/ready digest port.

## Interface
- `ROUNDS_PER_CYCLE`, default 1: compression rounds evaluated per clock. Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration `$fatal`.
- `clk_i`, input, 1: single clock, all logic on the rising edge.
- `rstn_i`, input, 1: reset, asynchronous and active-low.
- `blk_valid_i`, input, 1: a block is offered.
- `blk_ready_o`, output, 1: the core accepts a block.
- `blk_i`, input, 2*BLOCK_SIZE (512): padded block, word 0 in the MSBs.
- `blk_first_i`, input, 1: the offered block starts a new message.
- `blk_last_i`, input, 1: the offered block ends the message.
- `mode_i`, input, 1: 0 = SHA-256, 1 = SHA-224. Sampled only when a first block is accepted.
- `md_valid_o`, output, 1: digest available.
- `md_ready_i`, input, 1: consumer takes the digest.
- `md_o`, output, BLOCK_SIZE (256): digest. In SHA-224 mode it holds H0..H6 in bits [255:32], and bits [31:0] are 0.
- `busy_o`, output, 1: high in every state except IDLE.
- `blk_cnt_o`, output, 16: blocks compressed in the current message. It saturates at 16'hFFFF and clears when a first block is accepted.

## Operation
- States: IDLE, ROUND, UPDATE, WAIT, DONE.
- **Block accept:** a block is accepted on any edge where `blk_valid_i & blk_ready_o`. `blk_ready_o` = 1 only in IDLE and WAIT.
- **IDLE:**
  - On accept, H is loaded with the IV selected by `mode_i` (SHA-256 or SHA-224 constants), regardless of `blk_first_i`.
  - a..h are loaded from the IV, W[0..15] from `blk_i`, the round counter is cleared, and the state goes to ROUND.
- **ROUND:**
  - Each cycle performs `ROUNDS_PER_CYCLE` chained rounds.
  - The message schedule is a 16-word sliding window; new words use σ0/σ1 and K from `sha256_pkg`.
  - After 64/`ROUNDS_PER_CYCLE` cycles the state goes to UPDATE.
- **UPDATE:**
  - H[i] <= H[i] + a..h[i], mod 2^32 per word.
  - `blk_cnt_o` increments.
  - If the block was last, the state goes to DONE. Otherwise it goes to WAIT.
- **WAIT:**
  - An accept with `blk_first_i` = 0 continues the message: a..h <= H, load W, go to ROUND.
  - An accept with `blk_first_i` = 1 abandons the current message: reload the IV (resample `mode_i`), reset `blk_cnt_o` to 1 at UPDATE, then proceed as from IDLE.
- **DONE:**
  - `md_valid_o` = 1.
  - `md_o` is stable until the edge where `md_valid_o & md_ready_i`; that edge returns the state to IDLE.
  - `blk_ready_o` = 0 throughout DONE.
- `blk_last_i` and `blk_first_i` may both be 1: this is a single-block message.
- `blk_last_i` is latched at acceptance.
- `blk_i` is sampled only on the accept edge; it may change freely afterwards.

## Timing
- **Reset values:**
  - `blk_ready_o` = 0 while `rstn_i` is low, then 1 (IDLE).
  - `md_valid_o` = 0, `md_o` = 0, `busy_o` = 0, `blk_cnt_o` = 0.
  - H, a..h and W are cleared.
- **Latency:** with the accept edge at cycle N, `md_valid_o` goes high after edge N + 64/`ROUNDS_PER_CYCLE` + 1.
  - `ROUNDS_PER_CYCLE` = 1: 65 cycles.
  - `ROUNDS_PER_CYCLE` = 4: 17 cycles.
  - `ROUNDS_PER_CYCLE` = 16: 5 cycles.
- **Per-block throughput:** 64/`ROUNDS_PER_CYCLE` + 2 cycles when the next block is presented in WAIT immediately.
- **Reset mid-operation:** asserting `rstn_i` in any state returns to the reset values within the same cycle (asynchronous). No partial digest is ever presented.
- **Digest holdoff:** `md_valid_o` never drops without a handshake. A digest with `md_ready_i` held high leaves DONE one edge after `md_valid_o` rises.
- **Output register:** `md_o` is registered and updates only on the UPDATE→DONE edge.

## Test plan
- **Empty string, R=1:** single block 80000000_0…0 with first = last = 1 → `md_o` = e3b0c442…7852b855; `md_valid_o` rises exactly 65 cycles after the accept; `blk_cnt_o` = 1.
- **"abc", R=4:** 61626380_0…0_00000018 → ba7816bf…f20015ad after 17 cycles; the same block with `mode_i` = 1 → `md_o`[255:32] = 23097d22…e36c9da7 and `md_o`[31:0] = 0.
- **Two-block message:** "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", first block first = 1, second block last = 1, `blk_valid_i` gap of 7 cycles in WAIT → 248d6a61…19db06c1; `blk_cnt_o` = 2; `blk_ready_o` = 1 throughout the gap.
- **Backpressure:** `md_ready_i` held low 10 cycles after the "abc" digest → `md_valid_o` and `md_o` stable, `blk_ready_o` = 0; both drop to IDLE one edge after `md_ready_i` = 1.
- **Restart in WAIT:** the first half of the two-block message, then "abc" with first = last = 1 → ba7816bf…f20015ad and `blk_cnt_o` = 1.
- **Reset mid-ROUND:** `rstn_i` pulsed low at round 30 → all outputs at reset values immediately; a subsequent "abc" hashes correctly.
